// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: bundle between the run sequencer and its harness.
// Start is a level, not a valid/ready handshake. The controller samples it
// on every rising edge, but acts on it only in IDLE and DONE. The harness
// may hold it high or pulse it for one cycle. Start is ignored in PRE, RESET
// and RUN. All controller outputs are registered.
// State is a debug copy of the sequencer FSM for checkers.
// Encoding: 0 IDLE, 1 PRE, 2 RESET, 3 RUN, 4 DONE.
interface cpu_run_controller_if #(
   parameter int CNT_W = 32
);
   logic             Start;
   logic [31:0]      PC;
   logic [31:0]      Instruction;
   logic [31:0]      AluResult;
   logic             CpuRst;
   logic             Running;
   logic             Done;
   logic             Halted;
   logic             TimedOut;
   logic [CNT_W-1:0] CycleCount;
   logic [31:0]      LastPC;
   logic [31:0]      Signature;
   logic [2:0]       State;

   // harness side: drives Start and the core observation signals
   modport master (
      output Start, PC, Instruction, AluResult,
      input  CpuRst, Running, Done, Halted, TimedOut, CycleCount, LastPC,
             Signature, State
   );

   // controller side
   modport slave (
      input  Start, PC, Instruction, AluResult,
      output CpuRst, Running, Done, Halted, TimedOut, CycleCount, LastPC,
             Signature, State
   );
endinterface

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences the core reset through the PRE, RESET and RUN
// windows. It ends a run early on a halt word or a stalled PC, or at the end
// of the run budget. It then parks in DONE with the core held in reset.
// Optional feature macro: RUN_SIGNATURE_EN builds a 32-bit MISR over
// AluResult. Without it, Signature is tied to 0.
module cpu_run_controller #(
   parameter int          PRE_RST_CYCLES = 2,
   parameter int          RST_CYCLES     = 8,
   parameter int          RUN_CYCLES     = 10000,
   parameter int          HALT_WINDOW    = 4,
   parameter logic [31:0] HALT_INSTR     = 32'h0000000C,
   parameter int          CNT_W          = 32
) (
   input logic                 ClkIn,
   input logic                 Rst,
   cpu_run_controller_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_RESET = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // PRE_LAST is meaningless when PRE_RST_CYCLES is 0; PRE is skipped then.
   localparam logic [31:0]      PRE_LAST  = 32'(PRE_RST_CYCLES - 1);
   localparam logic [31:0]      RST_LAST  = 32'(RST_CYCLES - 1);
   localparam logic [31:0]      HALT_LIM  = 32'(HALT_WINDOW);
   localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   logic [31:0]      phase_cnt;
   logic [31:0]      prev_pc;
   logic [31:0]      stall_cnt;

   logic             start_go;
   logic             run_entry;
   logic [CNT_W-1:0] cnt_nxt;
   logic [31:0]      stall_nxt;
   logic             halt_hit;
   logic             timeout_hit;

   assign bus.State = state;

   // Next-cycle run bookkeeping and the exit conditions.
   // A CycleCount of 0 marks the first RUN cycle. That cycle has no valid
   // previous PC, so it never counts as a stall.
   always_comb begin
      start_go    = 1'b0;
      run_entry   = 1'b0;
      cnt_nxt     = bus.CycleCount + CNT_ONE;
      stall_nxt   = 32'd0;
      halt_hit    = 1'b0;
      timeout_hit = 1'b0;
      if (bus.Start && (state == ST_IDLE || state == ST_DONE)) begin
         start_go = 1'b1;
      end
      if (state == ST_RESET && phase_cnt == RST_LAST) begin
         run_entry = 1'b1;
      end
      if (bus.CycleCount != '0 && bus.PC == prev_pc) begin
         stall_nxt = stall_cnt + 32'd1;
      end
      halt_hit    = (bus.Instruction == HALT_INSTR) || (stall_nxt == HALT_LIM);
      timeout_hit = (cnt_nxt == RUN_LIMIT);
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge ClkIn) begin
      if (Rst) begin
         state          <= ST_IDLE;
         phase_cnt      <= 32'd0;
         prev_pc        <= 32'd0;
         stall_cnt      <= 32'd0;
         bus.CpuRst     <= 1'b0;
         bus.Running    <= 1'b0;
         bus.Done       <= 1'b0;
         bus.Halted     <= 1'b0;
         bus.TimedOut   <= 1'b0;
         bus.CycleCount <= '0;
         bus.LastPC     <= 32'd0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_go) begin
                  bus.Halted     <= 1'b0;
                  bus.TimedOut   <= 1'b0;
                  bus.CycleCount <= '0;
                  bus.Done       <= 1'b0;
                  phase_cnt      <= 32'd0;
                  if (PRE_RST_CYCLES == 0) begin
                     state      <= ST_RESET;
                     bus.CpuRst <= 1'b1;
                  end else begin
                     state      <= ST_PRE;
                     bus.CpuRst <= 1'b0;
                  end
               end
            end
            ST_PRE: begin
               if (phase_cnt == PRE_LAST) begin
                  phase_cnt  <= 32'd0;
                  state      <= ST_RESET;
                  bus.CpuRst <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt + 32'd1;
               end
            end
            ST_RESET: begin
               if (run_entry) begin
                  phase_cnt      <= 32'd0;
                  state          <= ST_RUN;
                  bus.CpuRst     <= 1'b0;
                  bus.Running    <= 1'b1;
                  bus.CycleCount <= '0;
                  stall_cnt      <= 32'd0;
               end else begin
                  phase_cnt <= phase_cnt + 32'd1;
               end
            end
            ST_RUN: begin
               bus.CycleCount <= cnt_nxt;
               prev_pc        <= bus.PC;
               stall_cnt      <= stall_nxt;
               if (halt_hit || timeout_hit) begin
                  state        <= ST_DONE;
                  bus.Running  <= 1'b0;
                  bus.Done     <= 1'b1;
                  bus.CpuRst   <= 1'b1;
                  bus.LastPC   <= bus.PC;
                  bus.Halted   <= halt_hit;
                  bus.TimedOut <= ~halt_hit;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef RUN_SIGNATURE_EN
   logic [31:0] sig_q;

   // MISR over AluResult. It clears at each sequence start and at RUN entry.
   // It is frozen outside RUN.
   always_ff @(posedge ClkIn) begin
      if (Rst || start_go || run_entry) begin
         sig_q <= 32'd0;
      end else if (state == ST_RUN) begin
         sig_q <= {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]}
                  ^ bus.AluResult;
      end
   end

   assign bus.Signature = sig_q;
`else
   logic unused_alu;
   assign unused_alu    = ^bus.AluResult;
   assign bus.Signature = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed checks of the run sequencer.
// The bench has three instances:
//   u_a uses the default parameters (long timeout run).
//   u_b uses RUN_CYCLES=20 (halts, stall, collision, Rst mid-run).
//   u_c uses PRE_RST_CYCLES=0, RST_CYCLES=1 and RUN_CYCLES=3 (short path, signature).
module tb_cpu_run_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] alu;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n;
   logic [31:0] exp_sig;

   cpu_run_controller_if #(.CNT_W(32)) if_a ();
   cpu_run_controller_if #(.CNT_W(32)) if_b ();
   cpu_run_controller_if #(.CNT_W(32)) if_c ();

   assign if_a.PC = pc;  assign if_a.Instruction = instr;  assign if_a.AluResult = alu;
   assign if_b.PC = pc;  assign if_b.Instruction = instr;  assign if_b.AluResult = alu;
   assign if_c.PC = pc;  assign if_c.Instruction = instr;  assign if_c.AluResult = alu;

   cpu_run_controller u_a (.ClkIn(clk), .Rst(rst), .bus(if_a.slave));
   cpu_run_controller #(.RUN_CYCLES(20)) u_b (.ClkIn(clk), .Rst(rst), .bus(if_b.slave));
   cpu_run_controller #(.PRE_RST_CYCLES(0), .RST_CYCLES(1), .RUN_CYCLES(3))
      u_c (.ClkIn(clk), .Rst(rst), .bus(if_c.slave));

   // clock
   always #5 clk = ~clk;

   // advance one edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int cnt);
      for (int i = 0; i < cnt; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one-cycle Start pulse to the selected instance
   task automatic pulse_start(input int which);
      case (which)
         0: if_a.Start = 1'b1;
         1: if_b.Start = 1'b1;
         default: if_c.Start = 1'b1;
      endcase
      tick();
      if_a.Start = 1'b0;
      if_b.Start = 1'b0;
      if_c.Start = 1'b0;
   endtask

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] a);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ a;
   endfunction

   initial begin
      rst = 1'b1; pc = 32'd0; instr = 32'd0; alu = 32'd0;
      if_a.Start = 1'b0; if_b.Start = 1'b0; if_c.Start = 1'b0;
      ticks(2);
      // reset state
      check("rst_cpurst",   {31'd0, if_a.CpuRst},   32'd0);
      check("rst_running",  {31'd0, if_a.Running},  32'd0);
      check("rst_done",     {31'd0, if_a.Done},     32'd0);
      check("rst_halted",   {31'd0, if_a.Halted},   32'd0);
      check("rst_timedout", {31'd0, if_a.TimedOut}, 32'd0);
      check("rst_count",    if_a.CycleCount,        32'd0);
      check("rst_lastpc",   if_a.LastPC,            32'd0);
      check("rst_sig",      if_a.Signature,         32'd0);
      check("rst_state",    {29'd0, if_a.State},    32'd0);
      rst = 1'b0;
      tick();

      // default parameters: full timeout run
      pulse_start(0);
      check("a_pre_state", {29'd0, if_a.State}, 32'd1);
      check("a_pre_cpurst0", {31'd0, if_a.CpuRst}, 32'd0);
      tick();
      check("a_pre_cpurst1", {31'd0, if_a.CpuRst}, 32'd0);
      tick();
      check("a_rst_rise", {31'd0, if_a.CpuRst}, 32'd1);
      ticks(7);
      check("a_rst_hold", {31'd0, if_a.CpuRst}, 32'd1);
      tick();
      check("a_rst_fall", {31'd0, if_a.CpuRst}, 32'd0);
      check("a_running",  {31'd0, if_a.Running}, 32'd1);
      n = 0;
      while (if_a.Running && n < 20000) begin
         pc = pc + 32'd4;
         tick();
         n++;
      end
      check("a_run_cycles", n,                       32'd10000);
      check("a_timedout",   {31'd0, if_a.TimedOut}, 32'd1);
      check("a_halted",     {31'd0, if_a.Halted},   32'd0);
      check("a_count",      if_a.CycleCount,        32'd10000);
      check("a_done",       {31'd0, if_a.Done},     32'd1);
      check("a_done_cpurst", {31'd0, if_a.CpuRst},  32'd1);
      check("a_lastpc",     if_a.LastPC,            32'd40000);
      check("a_sig",        if_a.Signature,         32'd0);

      // halt word on RUN cycle 15
      pulse_start(1);
      ticks(10);
      check("b1_running", {31'd0, if_b.Running}, 32'd1);
      for (int k = 1; k <= 15; k++) begin
         pc    = 32'h100 + 32'(4 * k);
         instr = (k == 15) ? 32'h0000000C : 32'd0;
         tick();
      end
      instr = 32'd0;
      check("b1_done",     {31'd0, if_b.Done},     32'd1);
      check("b1_halted",   {31'd0, if_b.Halted},   32'd1);
      check("b1_timedout", {31'd0, if_b.TimedOut}, 32'd0);
      check("b1_count",    if_b.CycleCount,        32'd15);
      check("b1_lastpc",   if_b.LastPC,            32'h0000013C);

      // stalled PC from RUN cycle 10, restart from DONE
      pulse_start(1);
      check("b2_restart_cpurst", {31'd0, if_b.CpuRst}, 32'd0);
      check("b2_restart_halted", {31'd0, if_b.Halted}, 32'd0);
      check("b2_restart_count",  if_b.CycleCount,      32'd0);
      check("b2_restart_done",   {31'd0, if_b.Done},   32'd0);
      ticks(10);
      for (int k = 1; k <= 13; k++) begin
         pc = (k >= 10) ? 32'h00000040 : 32'h200 + 32'(4 * k);
         tick();
      end
      check("b2_still_running", {31'd0, if_b.Running}, 32'd1);
      tick();
      check("b2_done",   {31'd0, if_b.Done},   32'd1);
      check("b2_halted", {31'd0, if_b.Halted}, 32'd1);
      check("b2_count",  if_b.CycleCount,      32'd14);
      check("b2_lastpc", if_b.LastPC,          32'h00000040);

      // halt word on the timeout cycle; Start held during RUN is ignored
      pulse_start(1);
      ticks(10);
      for (int k = 1; k <= 20; k++) begin
         pc         = 32'h300 + 32'(4 * k);
         instr      = (k == 20) ? 32'h0000000C : 32'd0;
         if_b.Start = (k == 5);
         tick();
      end
      if_b.Start = 1'b0;
      instr = 32'd0;
      check("b3_halted",   {31'd0, if_b.Halted},   32'd1);
      check("b3_timedout", {31'd0, if_b.TimedOut}, 32'd0);
      check("b3_count",    if_b.CycleCount,        32'd20);
      check("b3_lastpc",   if_b.LastPC,            32'h00000350);

      // Rst in RUN cycle 5, then a fresh sequence
      pulse_start(1);
      ticks(10);
      for (int k = 1; k <= 4; k++) begin
         pc = 32'h400 + 32'(4 * k);
         tick();
      end
      check("b4_count_pre_rst", if_b.CycleCount, 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("b4_state",    {29'd0, if_b.State},    32'd0);
      check("b4_cpurst",   {31'd0, if_b.CpuRst},   32'd0);
      check("b4_running",  {31'd0, if_b.Running},  32'd0);
      check("b4_done",     {31'd0, if_b.Done},     32'd0);
      check("b4_halted",   {31'd0, if_b.Halted},   32'd0);
      check("b4_timedout", {31'd0, if_b.TimedOut}, 32'd0);
      check("b4_count",    if_b.CycleCount,        32'd0);
      check("b4_lastpc",   if_b.LastPC,            32'd0);
      pulse_start(1);
      check("b4_new_state", {29'd0, if_b.State}, 32'd1);
      ticks(10);
      check("b4_new_running", {31'd0, if_b.Running}, 32'd1);
      check("b4_new_count0",  if_b.CycleCount,       32'd0);
      pc = 32'h500;
      tick();
      check("b4_new_count1",  if_b.CycleCount,       32'd1);

      // no PRE phase, one reset cycle, three RUN cycles
      pulse_start(2);
      check("c_cpurst_now", {31'd0, if_c.CpuRst},  32'd1);
      check("c_state_rst",  {29'd0, if_c.State},   32'd2);
      tick();
      check("c_running",    {31'd0, if_c.Running}, 32'd1);
      check("c_cpurst_off", {31'd0, if_c.CpuRst},  32'd0);
      for (int k = 1; k <= 3; k++) begin
         pc  = 32'h600 + 32'(4 * k);
         alu = 32'(k);
         tick();
      end
      alu = 32'd0;
`ifdef RUN_SIGNATURE_EN
      exp_sig = misr(misr(misr(32'd0, 32'd1), 32'd2), 32'd3);
`else
      exp_sig = 32'd0;
`endif
      check("c_timedout", {31'd0, if_c.TimedOut}, 32'd1);
      check("c_count",    if_c.CycleCount,        32'd3);
      check("c_sig",      if_c.Signature,         exp_sig);
      tick();
      check("c_sig_frozen", if_c.Signature,       exp_sig);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
